// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and types for the PC / fetch loop; also used by jump control and decode.
package pc_fetch_unit_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned INS_W  = 24;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INS_W-1:0]  ins_t;

    localparam addr_t RESET_PC = 8'h00;
    localparam ins_t  NOP_INS  = 24'h000000;

    // Source of the next program counter value
    typedef enum logic [1:0] {
        PC_SEL_SEQ  = 2'd0,
        PC_SEL_JMP  = 2'd1,
        PC_SEL_PEND = 2'd2,
        PC_SEL_HOLD = 2'd3
    } pc_sel_e;

    // Fetched instruction together with its address
    typedef struct packed {
        ins_t  ins;
        addr_t addr;
    } fetch_out_t;

    // Stall dominates; a live jump beats a parked one
    function automatic pc_sel_e pc_sel_decode(input logic stall, input logic jmp, input logic pend);
        pc_sel_e sel;
        sel = PC_SEL_SEQ;
        if (stall) begin
            sel = PC_SEL_HOLD;
        end else if (jmp) begin
            sel = PC_SEL_JMP;
        end else if (pend) begin
            sel = PC_SEL_PEND;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Combinational next-PC selector: sequential, live jump, parked jump or hold.
module pc_next_sel
    import pc_fetch_unit_pkg::*;
(
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] jmp_loc_i,
    input  logic [ADDR_W-1:0] pend_loc_i,
    input  logic              stall_i,
    input  logic              pc_mux_sel_i,
    input  logic              pend_i,
    output logic [ADDR_W-1:0] pc_d_o,
    output pc_sel_e           sel_o
);

    always_comb begin
        sel_o  = pc_sel_decode(stall_i, pc_mux_sel_i, pend_i);
        pc_d_o = pc_i;
        unique case (sel_o)
            PC_SEL_SEQ:  pc_d_o = pc_i + ADDR_W'(1);
            PC_SEL_JMP:  pc_d_o = jmp_loc_i;
            PC_SEL_PEND: pc_d_o = pend_loc_i;
            PC_SEL_HOLD: pc_d_o = pc_i;
            default:     pc_d_o = pc_i;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage with 1-cycle memory, stall hold,
// jump parking during stall and a single-bubble squash on every redirect.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] jmp_loc,
    input  logic              pc_mux_sel,
    input  logic              stall,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [INS_W-1:0]  imem_data,
    output logic [INS_W-1:0]  ins,
    output logic [ADDR_W-1:0] Current_Address,
    output logic              ins_valid
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic              pend_q;
    logic [ADDR_W-1:0] pend_loc_q;
    pc_sel_e           sel;

    pc_next_sel u_pc_next_sel (
        .pc_i         (pc_q),
        .jmp_loc_i    (jmp_loc),
        .pend_loc_i   (pend_loc_q),
        .stall_i      (stall),
        .pc_mux_sel_i (pc_mux_sel),
        .pend_i       (pend_q),
        .pc_d_o       (pc_d),
        .sel_o        (sel)
    );

    // A redirect squashes the read issued from the old path, so only sequential edges validate
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            valid_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_loc_q <= '0;
        end else if (stall) begin
            if (pc_mux_sel) begin
                pend_q     <= 1'b1;
                pend_loc_q <= jmp_loc;
            end
        end else begin
            pc_q    <= pc_d;
            addr_q  <= pc_q;
            valid_q <= (sel == PC_SEL_SEQ);
            pend_q  <= 1'b0;
        end
    end

    assign imem_addr       = pc_q;
    assign imem_rd         = reset & ~stall;
    assign ins             = valid_q ? imem_data : NOP_INS;
    assign Current_Address = addr_q;
    assign ins_valid       = valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expected fetches queued by stimulus, checked by a monitor.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  jmp_loc;
    logic        pc_mux_sel;
    logic        stall;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [23:0] imem_data;
    logic [23:0] ins;
    logic [7:0]  Current_Address;
    logic        ins_valid;

    int n_vec;
    int n_bad;
    logic adv;
    fetch_out_t expq[$];

    pc_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .jmp_loc         (jmp_loc),
        .pc_mux_sel      (pc_mux_sel),
        .stall           (stall),
        .imem_addr       (imem_addr),
        .imem_rd         (imem_rd),
        .imem_data       (imem_data),
        .ins             (ins),
        .Current_Address (Current_Address),
        .ins_valid       (ins_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word[a] = {16'h0, a}, data held while no read
    initial imem_data = 24'h0;
    always @(posedge clk) if (imem_rd) imem_data <= {16'h0, imem_addr};

    // A new instruction is presented after every unstalled edge out of reset
    initial adv = 1'b0;
    always @(posedge clk) adv <= reset && !stall;

    always @(negedge clk) begin
        if (adv && ins_valid) begin
            n_vec++;
            if (expq.size() == 0) begin
                n_bad++;
                $display("FAIL fetch_unexpected: got ins=%h addr=%h, required none", ins, Current_Address);
            end else begin
                fetch_out_t e;
                e = expq.pop_front();
                if (ins !== e.ins || Current_Address !== e.addr) begin
                    n_bad++;
                    $display("FAIL fetch: got ins=%h addr=%h, required ins=%h addr=%h",
                             ins, Current_Address, e.ins, e.addr);
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] a);
        fetch_out_t e;
        e.ins  = {16'h0, a};
        e.addr = a;
        expq.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic m, input logic [7:0] l);
        stall      = s;
        pc_mux_sel = m;
        jmp_loc    = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        reset      = 1'b0;
        stall      = 1'b0;
        pc_mux_sel = 1'b0;
        jmp_loc    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ins_valid", 32'(ins_valid), 32'h0);
        chk("rst_ins", 32'(ins), 32'h0);
        chk("rst_addr", 32'(Current_Address), 32'h0);
        chk("rst_imem_addr", 32'(imem_addr), 32'h0);
        chk("rst_imem_rd", 32'(imem_rd), 32'h0);

        reset = 1'b1;
        #1;
        chk("rel_imem_rd", 32'(imem_rd), 32'h1);
        chk("rel_ins_valid", 32'(ins_valid), 32'h0);

        // Sequential run from RESET_PC
        push_exp(8'h00); push_exp(8'h01); push_exp(8'h02); push_exp(8'h03);
        cyc(0, 0, 8'h00);
        chk("seq_imem_addr1", 32'(imem_addr), 32'h01);
        cyc(0, 0, 8'h00);
        chk("seq_imem_addr2", 32'(imem_addr), 32'h02);
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);

        // Jump to 08 while 03 is presented
        cyc(0, 1, 8'h08);
        chk("jmp_bubble_valid", 32'(ins_valid), 32'h0);
        chk("jmp_bubble_ins", 32'(ins), 32'h0);
        chk("jmp_imem_addr", 32'(imem_addr), 32'h08);
        push_exp(8'h08); push_exp(8'h09); push_exp(8'h0A);
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);

        // Three stalled cycles hold everything at 0A
        stall = 1'b1;
        #1;
        chk("stall_imem_rd", 32'(imem_rd), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 8'h00);
            chk("stall_addr", 32'(Current_Address), 32'h0A);
            chk("stall_ins", 32'(ins), 32'h00000A);
            chk("stall_pc", 32'(imem_addr), 32'h0B);
        end
        push_exp(8'h0B); push_exp(8'h0C);
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);

        // Two jumps parked during a stall: last one wins
        cyc(1, 1, 8'h10);
        cyc(1, 1, 8'h20);
        chk("park_hold_addr", 32'(Current_Address), 32'h0C);
        cyc(0, 0, 8'h00);
        chk("park_bubble_valid", 32'(ins_valid), 32'h0);
        chk("park_imem_addr", 32'(imem_addr), 32'h20);
        push_exp(8'h20); push_exp(8'h21);
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);

        // Back-to-back redirects: 30 is squashed, 40 is fetched
        cyc(0, 1, 8'h30);
        cyc(0, 1, 8'h40);
        chk("b2b_valid", 32'(ins_valid), 32'h0);
        chk("b2b_addr", 32'(Current_Address), 32'h30);
        chk("b2b_imem_addr", 32'(imem_addr), 32'h40);
        push_exp(8'h40);
        cyc(0, 0, 8'h00);

        // PC wrap from FF to 00
        cyc(0, 1, 8'hFE);
        chk("wrap_imem_fe", 32'(imem_addr), 32'hFE);
        push_exp(8'hFE); push_exp(8'hFF); push_exp(8'h00); push_exp(8'h01);
        cyc(0, 0, 8'h00);
        chk("wrap_imem_ff", 32'(imem_addr), 32'hFF);
        cyc(0, 0, 8'h00);
        chk("wrap_imem_00", 32'(imem_addr), 32'h00);
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);

        // Async reset while stalled with a parked jump to F0
        cyc(1, 1, 8'hF0);
        pc_mux_sel = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", 32'(ins_valid), 32'h0);
        chk("async_ins", 32'(ins), 32'h0);
        chk("async_addr", 32'(Current_Address), 32'h0);
        chk("async_imem_addr", 32'(imem_addr), 32'h0);
        chk("async_imem_rd", 32'(imem_rd), 32'h0);
        @(posedge clk);
        #1;
        stall = 1'b0;
        reset = 1'b1;
        push_exp(8'h00); push_exp(8'h01);
        cyc(0, 0, 8'h00);
        chk("post_rst_imem_addr", 32'(imem_addr), 32'h01);
        cyc(0, 0, 8'h00);
        stall = 1'b1;

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
